// File: rtl/frame_thresholder_pkg.sv
// Shared definitions for the framed-sample thresholder: default frame markers,
// FSM state encoding and trigger-mode encodings.
package frame_thresholder_pkg;

   localparam logic [15:0] START_WORD_DEF = 16'hDEAD;
   localparam logic [15:0] END_WORD_DEF   = 16'hBEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TS   = 2'd1,
      ST_DATA = 2'd2,
      ST_END  = 2'd3
   } fsm_state_t;

   typedef enum logic {
      MODE_ABOVE = 1'b0,
      MODE_BELOW = 1'b1
   } trig_mode_t;

endpackage

// File: rtl/frame_thresholder_run_detector.sv
// Per-lane sample qualifier: strict threshold comparison, consecutive-run counter
// and a one-shot that allows at most one accepted hit per frame.
module thr_run_detector
   import frame_thresholder_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic              clear,
   input  logic              fire,
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] threshold,
   input  logic              trig_mode,
   input  logic [CNT_W-1:0]  min_over,
   output logic              hit
);

   logic [CNT_W-1:0] run_cnt_reg;
   logic             fired_reg;
   logic             qualify;
   logic [CNT_W:0]   need;
   logic [CNT_W:0]   run_plus;

   always_comb begin
      qualify  = (trig_mode == MODE_BELOW) ? (sample < threshold) : (sample > threshold);
      need     = (min_over == '0) ? (CNT_W+1)'(1) : {1'b0, min_over};
      run_plus = {1'b0, run_cnt_reg} + (CNT_W+1)'(1);
      // Hit only on the sample where the run first reaches the target length.
      hit      = sample_valid && qualify && (run_plus == need) && !fired_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt_reg <= '0;
         fired_reg   <= 1'b0;
      end else if (clear) begin
         run_cnt_reg <= '0;
         fired_reg   <= 1'b0;
      end else begin
         if (sample_valid) begin
            if (!qualify)
               run_cnt_reg <= '0;
            else if (!(&run_cnt_reg))
               run_cnt_reg <= run_cnt_reg + CNT_W'(1);
         end
         if (fire)
            fired_reg <= 1'b1;
      end
   end

endmodule

// File: rtl/frame_thresholder.sv
// Frame parser and trigger requester: tracks framed RX words, qualifies DATA
// samples through the run detector and handshakes a global trigger with holdoff.
module frame_thresholder
   import frame_thresholder_pkg::*;
#(
   parameter int              DATA_W      = 16,
   parameter int              SYNC_W      = 2,
   parameter int              FRAME_LEN   = 128,
   parameter logic [DATA_W-1:0] START_WORD = DATA_W'(START_WORD_DEF),
   parameter logic [DATA_W-1:0] END_WORD   = DATA_W'(END_WORD_DEF),
   parameter int              CNT_W       = 4,
   parameter int              HOLDOFF_CYC = 64,
   parameter int              IDX_W       = $clog2(FRAME_LEN)
) (
   input  logic              rx_std_clkout,
   input  logic              rst,
   input  logic [SYNC_W-1:0] rx_syncstatus,
   input  logic [SYNC_W-1:0] rx_datak,
   input  logic [DATA_W-1:0] RX_data,
   input  logic [DATA_W-1:0] threshold,
   input  logic              trig_mode,
   input  logic [CNT_W-1:0]  min_over,
   input  logic              Global_trigger_flag,
   output logic              set_global_trigger,
   output logic [DATA_W-1:0] time_stamp,
   output logic [IDX_W-1:0]  trig_index,
   output logic              frame_done,
   output logic [15:0]       frame_err_cnt
);

   localparam int HO_W = $clog2(HOLDOFF_CYC + 1);

   fsm_state_t        state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg, idx_next;
   logic [DATA_W-1:0] ts_reg;
   logic [HO_W-1:0]   hold_reg;
   logic              set_reg;
   logic [DATA_W-1:0] time_stamp_reg;
   logic [IDX_W-1:0]  trig_index_reg;
   logic              frame_done_reg;
   logic [15:0]       err_reg;

   logic link_ok;
   logic frame_start, abort, end_ok, end_bad, ts_load;
   logic sample_valid, hit, fire;

   assign link_ok      = (&rx_syncstatus) && (rx_datak == '0);
   assign sample_valid = (state_reg == ST_DATA) && link_ok;

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      frame_start = 1'b0;
      abort       = 1'b0;
      end_ok      = 1'b0;
      end_bad     = 1'b0;
      ts_load     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (link_ok && RX_data == START_WORD) begin
               state_next  = ST_TS;
               idx_next    = IDX_W'(1);
               frame_start = 1'b1;
            end
         end
         ST_TS: begin
            idx_next = idx_reg + IDX_W'(1);
            if (!link_ok) begin
               abort = 1'b1;
            end else begin
               ts_load    = 1'b1;
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            idx_next = idx_reg + IDX_W'(1);
            if (!link_ok)
               abort = 1'b1;
            else if (idx_reg == IDX_W'(FRAME_LEN - 2))
               state_next = ST_END;
         end
         ST_END: begin
            state_next = ST_IDLE;
            idx_next   = '0;
            if (!link_ok)
               abort = 1'b1;
            else if (RX_data == END_WORD)
               end_ok = 1'b1;
            else
               end_bad = 1'b1;
         end
         default: begin
            state_next = ST_IDLE;
            idx_next   = '0;
         end
      endcase
      if (abort) begin
         state_next = ST_IDLE;
         idx_next   = '0;
      end
   end

   thr_run_detector #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_run_detector (
      .clk          (rx_std_clkout),
      .rst          (rst),
      .sample_valid (sample_valid),
      .clear        (frame_start || abort),
      .fire         (fire),
      .sample       (RX_data),
      .threshold    (threshold),
      .trig_mode    (trig_mode),
      .min_over     (min_over),
      .hit          (hit)
   );

   // The flag always wins over a same-cycle hit.
   assign fire = hit && (hold_reg == '0) && !set_reg && !Global_trigger_flag;

   always_ff @(posedge rx_std_clkout or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         idx_reg        <= '0;
         ts_reg         <= '0;
         hold_reg       <= '0;
         set_reg        <= 1'b0;
         time_stamp_reg <= '0;
         trig_index_reg <= '0;
         frame_done_reg <= 1'b0;
         err_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         frame_done_reg <= end_ok;
         if (ts_load)
            ts_reg <= RX_data;
         if (fire) begin
            set_reg        <= 1'b1;
            time_stamp_reg <= ts_reg;
            trig_index_reg <= idx_reg;
         end else if (Global_trigger_flag) begin
            set_reg <= 1'b0;
         end
         if (Global_trigger_flag)
            hold_reg <= HO_W'(HOLDOFF_CYC);
         else if (hold_reg != '0)
            hold_reg <= hold_reg - HO_W'(1);
         if ((abort || end_bad) && err_reg != 16'hFFFF)
            err_reg <= err_reg + 16'd1;
      end
   end

   assign set_global_trigger = set_reg;
   assign time_stamp         = time_stamp_reg;
   assign trig_index         = trig_index_reg;
   assign frame_done         = frame_done_reg;
   assign frame_err_cnt      = err_reg;

endmodule

// File: tb/tb_frame_thresholder.sv
// Directed bench for frame_thresholder: frame-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_frame_thresholder;

   localparam int FRAME_LEN = 128;
   localparam int HOLDOFF   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sync;
   logic [1:0]  datak;
   logic [15:0] rx;
   logic [15:0] threshold;
   logic        mode;
   logic [3:0]  min_over;
   logic        gtf;
   logic        set_gt;
   logic [15:0] ts_o;
   logic [6:0]  idx_o;
   logic        done_o;
   logic [15:0] err_o;

   frame_thresholder dut (
      .rx_std_clkout       (clk),
      .rst                 (rst),
      .rx_syncstatus       (sync),
      .rx_datak            (datak),
      .RX_data             (rx),
      .threshold           (threshold),
      .trig_mode           (mode),
      .min_over            (min_over),
      .Global_trigger_flag (gtf),
      .set_global_trigger  (set_gt),
      .time_stamp          (ts_o),
      .trig_index          (idx_o),
      .frame_done          (done_o),
      .frame_err_cnt       (err_o)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int done_count  = 0;
   bit check_en    = 1'b0;

   // Reference model state: frame position, run length, handshake and holdoff.
   bit          m_in_frame;
   int          m_pos;
   int          m_run;
   bit          m_fired;
   logic [15:0] m_ts;
   int          m_hold;
   bit          e_set;
   logic [15:0] e_ts;
   int          e_idx;
   bit          e_done;
   int          e_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in_frame = 0; m_pos = 0; m_run = 0; m_fired = 0; m_ts = '0; m_hold = 0;
      e_set = 0; e_ts = '0; e_idx = 0; e_done = 0; e_err = 0;
   endtask

   task automatic bump_err();
      if (e_err < 65535) e_err++;
   endtask

   task automatic model_update();
      bit link;
      bit cand;
      bit done_nx;
      bit qual;
      int need;
      int cur;
      link    = (sync == 2'b11) && (datak == 2'b00);
      need    = (min_over == 0) ? 1 : int'(min_over);
      cand    = 0;
      done_nx = 0;
      cur     = m_pos;
      if (m_in_frame) begin
         if (!link) begin
            bump_err();
            m_in_frame = 0;
            m_run      = 0;
         end else if (m_pos == 1) begin
            m_ts  = rx;
            m_pos = 2;
         end else if (m_pos <= FRAME_LEN - 2) begin
            qual  = mode ? (rx < threshold) : (rx > threshold);
            m_run = qual ? m_run + 1 : 0;
            cand  = qual && (m_run == need);
            m_pos++;
         end else begin
            if (rx == 16'hBEEF) done_nx = 1;
            else bump_err();
            m_in_frame = 0;
         end
      end else if (link && rx == 16'hDEAD) begin
         m_in_frame = 1;
         m_pos      = 1;
         m_run      = 0;
         m_fired    = 0;
      end
      if (cand && !m_fired && m_hold == 0 && !e_set && !gtf) begin
         e_set   = 1;
         e_ts    = m_ts;
         e_idx   = cur;
         m_fired = 1;
      end else if (gtf) begin
         e_set = 0;
      end
      m_hold = gtf ? HOLDOFF : ((m_hold > 0) ? m_hold - 1 : 0);
      e_done = done_nx;
   endtask

   // Single compare process: every cycle, DUT outputs against the model.
   always @(negedge clk) begin
      if (done_o === 1'b1) done_count++;
      if (check_en) begin
         check("set_global_trigger", set_gt, e_set);
         check("time_stamp", ts_o, e_ts);
         check("trig_index", idx_o, e_idx);
         check("frame_done", done_o, e_done);
         check("frame_err_cnt", err_o, e_err);
      end
   end

   task automatic step(input logic [15:0] w, input logic [1:0] s, input logic g, input logic r);
      @(negedge clk);
      #1;
      rx = w; sync = s; gtf = g; rst = r;
      if (r) model_reset();
      @(posedge clk);
      if (r) model_reset();
      else model_update();
   endtask

   task automatic idle(input int n, input logic g);
      for (int k = 0; k < n; k++) step(16'h0000, 2'b11, g, 1'b0);
   endtask

   function automatic logic [15:0] sample_word(input int kind, input int i);
      logic [15:0] v;
      case (kind)
         0: v = 16'(i);
         1: v = ((i >= 60 && i <= 63) || (i % 2 == 1 && (i < 59 || i > 64))) ? 16'h0060 : 16'h0040;
         2: v = (i <= 10) ? 16'h0060 : 16'h0010;
         3: v = (i == 50) ? 16'h000F : 16'h0020;
         default: v = 16'h0000;
      endcase
      return v;
   endfunction

   task automatic send_frame(input logic [15:0] ts, input int kind, input logic [15:0] endw,
                             input int abort_idx, input int rst_idx, input int pre_rst_idx);
      logic [15:0] w;
      for (int i = 0; i < FRAME_LEN; i++) begin
         w = (i == 0) ? 16'hDEAD : (i == 1) ? ts : (i == FRAME_LEN - 1) ? endw : sample_word(kind, i);
         if (i == rst_idx) begin
            #2;
            check("pre_rst_trig_index", idx_o, pre_rst_idx);
            step(w, 2'b11, 1'b0, 1'b1);
            $display("frame ts=%h kind=%0d reset at index %0d", ts, kind, i);
            return;
         end
         step(w, (i == abort_idx) ? 2'b01 : 2'b11, 1'b0, 1'b0);
      end
      $display("frame ts=%h kind=%0d end=%h abort=%0d", ts, kind, endw, abort_idx);
   endtask

   initial begin
      rst = 1'b1; sync = 2'b00; datak = 2'b00; rx = '0; gtf = 1'b0;
      threshold = 16'h0050; mode = 1'b0; min_over = 4'd1;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check("reset_set", set_gt, 0);
      check("reset_err", err_o, 0);
      check("reset_idx", idx_o, 0);
      check_en = 1'b1;
      idle(3, 1'b0);

      // 1: ramp frame, first sample above 0x50 is 0x51 at index 81
      send_frame(16'h0045, 0, 16'hBEEF, -1, -1, 0);
      idle(2, 1'b0);
      #2;
      check("t1_time_stamp", ts_o, 16'h0045);
      check("t1_trig_index", idx_o, 81);
      check("t1_set", set_gt, 1);
      check("t1_err", err_o, 0);
      check("t1_done_count", done_count, 1);

      // 3: request held without flag, cleared by flag, then holdoff blocks a frame
      idle(10, 1'b0);
      #2;
      check("t3_set_held", set_gt, 1);
      idle(1, 1'b1);
      #2;
      check("t3_set_cleared", set_gt, 0);
      send_frame(16'h0046, 2, 16'hBEEF, -1, -1, 0);
      idle(2, 1'b0);
      #2;
      check("t3_holdoff_no_trig", set_gt, 0);
      check("t3_index_held", idx_o, 81);
      idle(70, 1'b0);

      // 2: min_over=4, only indices 60..63 form a run of four
      min_over = 4'd4;
      send_frame(16'h0047, 1, 16'hBEEF, -1, -1, 0);
      idle(2, 1'b0);
      #2;
      check("t2_trig_index", idx_o, 63);
      check("t2_time_stamp", ts_o, 16'h0047);
      check("t2_set", set_gt, 1);
      idle(1, 1'b1);
      idle(70, 1'b0);

      // 4: bad END word, trigger stays asserted
      min_over = 4'd1;
      send_frame(16'h0048, 0, 16'hBEEE, -1, -1, 0);
      idle(2, 1'b0);
      #2;
      check("t4_err", err_o, 1);
      check("t4_set", set_gt, 1);
      check("t4_done_count", done_count, 3);
      idle(1, 1'b1);
      idle(70, 1'b0);

      // 5: sync loss at index 40, then resync
      send_frame(16'h0049, 0, 16'hBEEF, 40, -1, 0);
      idle(2, 1'b0);
      #2;
      check("t5_err", err_o, 2);
      check("t5_no_trig", set_gt, 0);
      send_frame(16'h004A, 0, 16'hBEEF, -1, -1, 0);
      idle(2, 1'b0);
      #2;
      check("t5_resync_idx", idx_o, 81);
      check("t5_resync_ts", ts_o, 16'h004A);
      check("t5_done_count", done_count, 4);
      idle(1, 1'b1);
      idle(70, 1'b0);

      // 6: below-mode trigger on 0x000F, reset mid-frame
      mode = 1'b1; threshold = 16'h0010;
      send_frame(16'h004B, 3, 16'hBEEF, -1, 70, 50);
      #2;
      check("t6_rst_set", set_gt, 0);
      check("t6_rst_ts", ts_o, 0);
      check("t6_rst_idx", idx_o, 0);
      check("t6_rst_err", err_o, 0);
      check("t6_rst_done", done_o, 0);
      idle(3, 1'b0);

      mode = 1'b0; threshold = 16'h0050;
      send_frame(16'h004C, 0, 16'hBEEF, -1, -1, 0);
      idle(2, 1'b0);
      #2;
      check("post_rst_idx", idx_o, 81);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frame_thresholder.md
Name: frame_thresholder

Overview:
Parametrised successor to the single-lane link thresholder. Parses framed sample words from the transceiver RX interface, compares each sample against a runtime threshold in a selectable mode, and requires N consecutive qualifying samples. On a hit it raises a global-trigger request, handshaken against the shared global trigger flag, and enforces a holdoff. Also checks frame integrity and counts framing errors. Sits between the transceiver RX word output and the global trigger logic.

Parameters:
DATA_W, 16, RX word / sample width
SYNC_W, 2, width of rx_syncstatus and rx_datak
FRAME_LEN, 128, words per frame including start, timestamp and end words (min 4)
START_WORD, 16'hDEAD, frame start marker
END_WORD, 16'hBEEF, frame end marker
CNT_W, 4, width of min_over
HOLDOFF_CYC, 64, cycles to suppress triggering after any global trigger is seen
IDX_W, $clog2(FRAME_LEN), word index width

Ports:
rx_std_clkout  in  1  clock
rst  in  1  asynchronous active-high reset
rx_syncstatus  in  SYNC_W  per-byte sync status
rx_datak  in  SYNC_W  control-character flags
RX_data  in  DATA_W  received word
threshold  in  DATA_W  unsigned threshold; quasi-static
trig_mode  in  1  0: sample > threshold; 1: sample < threshold
min_over  in  CNT_W  consecutive qualifying samples needed; 0 is treated as 1
Global_trigger_flag  in  1  global trigger asserted or acknowledged
set_global_trigger  out  1  trigger request
time_stamp  out  DATA_W  timestamp word of the triggering frame
trig_index  out  IDX_W  word index of the sample that completed the run
frame_done  out  1  1-cycle pulse when a frame ends correctly
frame_err_cnt  out  16  saturating framing-error count

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; run counter, holdoff counter and word index all 0.
- link_ok = (&rx_syncstatus) && (rx_datak == 0). All inputs are sampled on the rising edge of rx_std_clkout.
- FSM states:
  - IDLE: on link_ok && RX_data == START_WORD, go to TS with index 1.
  - TS: latch RX_data into the internal timestamp register; go to DATA.
  - DATA: runs for word indices 2..FRAME_LEN-2; at index FRAME_LEN-2, go to END.
  - END: if RX_data == END_WORD, pulse frame_done next cycle; otherwise increment frame_err_cnt. Either way, return to IDLE.
- Words are back-to-back. The index increments every cycle outside IDLE.
- If link_ok drops in TS, DATA or END: abort to IDLE, increment frame_err_cnt, clear the run counter.
- START_WORD seen inside DATA is treated as data, not a resync.
- Qualify, in DATA only: strict comparison per trig_mode. A qualifying sample increments the run counter; any non-qualifying sample clears it. The run counter clears on every frame start.
- Hit condition: the run count reaches max(min_over, 1), AND no trigger has yet been issued this frame, AND holdoff is 0, AND set_global_trigger is 0.
- On a hit, on the next edge (1-cycle latency):
  - set_global_trigger goes to 1;
  - time_stamp takes the frame timestamp;
  - trig_index takes the index of that sample.
- set_global_trigger holds until Global_trigger_flag is sampled high, then clears on the following edge.
- A trigger is not retracted if the frame later fails.
- Holdoff:
  - Any cycle with Global_trigger_flag high, whether an acknowledgement or a trigger from another source, loads the holdoff counter with HOLDOFF_CYC.
  - The counter decrements to 0 otherwise; a hit is blocked while it is nonzero.
- Hit and Global_trigger_flag in the same cycle: the flag wins, the hit is suppressed and holdoff is loaded.
- frame_err_cnt saturates at 16'hFFFF.
- time_stamp and trig_index hold their values until the next trigger.
- Reset mid-frame: immediate return to reset values.

Decomposition:
- Shared package: START_WORD/END_WORD defaults, the FSM state enum, and the trig_mode encodings.
- One natural sub-module, thr_run_detector: comparator, run counter and per-frame one-shot, reused per lane in a future multi-lane top.

Test Plan:
1. Reset, then link_ok; one frame with START 16'hDEAD, TS 16'h0045, samples 16'h0002..16'h007E, END 16'hBEEF; threshold=16'h0050, mode 0, min_over=1.
   -> set_global_trigger rises 1 cycle after sample 16'h0051 is captured; time_stamp=16'h0045, trig_index=81; frame_done pulses once; frame_err_cnt=0.
2. Same frame with min_over=4, and samples alternating above/below 16'h0050 except 4 consecutive above at indices 60..63.
   -> trigger at index 63 only.
3. Global_trigger_flag tied low for 10 cycles after a trigger, then pulsed.
   -> set_global_trigger stays high until 1 edge after the flag.
   -> a qualifying frame starting within 64 cycles gives no trigger; one starting after gives a trigger.
4. END word 16'hBEEE.
   -> frame_err_cnt=1, no frame_done; a trigger already raised in that frame stays asserted.
5. rx_syncstatus=2'b01 for one cycle at index 40.
   -> abort, frame_err_cnt increments, no trigger from that frame; the next 16'hDEAD resynchronises.
6. Mode 1, threshold 16'h0010, data 16'h0020 except one sample 16'h000F; plus assert rst at index 70.
   -> trigger on 16'h000F; after rst, all outputs are 0 and the FSM is in IDLE.
